// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline constants, controlBus bit positions and register-file state encoding
package pipeline_pkg;
  localparam int NUM_REGS = 16;
  localparam logic [3:0] REG_RA = 4'd15;
  localparam logic [3:0] REG_SP = 4'd14;
  localparam logic [4:0] HALT_OPCODE = 5'b11111;
  localparam int IS_LD = 1;
  localparam int IS_WB = 6;
  localparam int IS_CALL = 8;
  typedef enum logic [1:0] {RUN, DUMP, HALT} rf_state_e;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one read port with same-cycle writeback bypass
module regfile_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              i_byp_en,
  input  logic [ADDR_W-1:0] i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_reg_data,
  output logic [DATA_W-1:0] o_data
);
  assign o_data = (i_byp_en && i_wb_rd == i_rd_addr) ? i_wb_data : i_reg_data;
endmodule

// File: rtl/operand_regfile.sv
// operand_regfile: bypassed 2R1W register file with halt state and write counter; REGFILE_DUMP_EN adds a post-halt register dump
module operand_regfile
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_FFFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_last,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              halted,
  output logic [31:0]       wr_count,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data
);
  localparam int N = 1 << ADDR_W;
  logic [DATA_W-1:0] r_regs [N];
  rf_state_e r_state;
  logic r_halted;
  logic [31:0] r_wr_count;
  logic w_byp;
`ifdef REGFILE_DUMP_EN
  logic r_dump_valid;
  logic [ADDR_W-1:0] r_dump_idx;
  assign dump_valid = r_dump_valid;
  assign dump_idx = r_dump_idx;
  assign dump_data = r_dump_valid ? r_regs[r_dump_idx] : '0;
`else
  assign dump_valid = 1'b0;
  assign dump_idx = '0;
  assign dump_data = '0;
`endif
  assign halted = r_halted;
  assign wr_count = r_wr_count;
  // Only RUN may forward writeback data; once halted the file is frozen.
  assign w_byp = (r_state == RUN) && wb_en;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_regs[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
      r_state <= RUN;
      r_halted <= 1'b0;
      r_wr_count <= '0;
`ifdef REGFILE_DUMP_EN
      r_dump_valid <= 1'b0;
      r_dump_idx <= '0;
`endif
    end else begin
      case (r_state)
        RUN: begin
          if (wb_en) begin
            r_regs[wb_rd] <= wb_data;
            r_wr_count <= r_wr_count + 32'd1;
          end
          if (wb_last) begin
            r_halted <= 1'b1;
`ifdef REGFILE_DUMP_EN
            r_state <= DUMP;
            r_dump_valid <= 1'b1;
            r_dump_idx <= '0;
`else
            r_state <= HALT;
`endif
          end
        end
`ifdef REGFILE_DUMP_EN
        DUMP: begin
          r_dump_idx <= r_dump_idx + 1'b1;
          if (r_dump_idx == ADDR_W'(N - 1)) begin
            r_dump_valid <= 1'b0;
            r_state <= HALT;
          end
        end
`endif
        default: ;
      endcase
    end
  end
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
    .i_byp_en(w_byp), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .i_rd_addr(rd_addr1), .i_reg_data(r_regs[rd_addr1]), .o_data(rd_data1)
  );
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
    .i_byp_en(w_byp), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .i_rd_addr(rd_addr2), .i_reg_data(r_regs[rd_addr2]), .o_data(rd_data2)
  );
endmodule

// File: tb/tb_operand_regfile.sv
// tb_operand_regfile: directed self-checking bench for operand_regfile (dump checks when REGFILE_DUMP_EN is defined)
module tb_operand_regfile;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wb_en = 1'b0;
  logic [3:0] wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic wb_last = 1'b0;
  logic [3:0] rd_addr1 = '0;
  logic [3:0] rd_addr2 = '0;
  logic [31:0] rd_data1, rd_data2, wr_count, dump_data;
  logic halted, dump_valid;
  logic [3:0] dump_idx;
  int n_tot = 0;
  int n_fail = 0;
  logic [31:0] exp_regs [16];

  operand_regfile dut (
    .clk(clk), .reset(reset), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_last(wb_last), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
    .rd_addr2(rd_addr2), .rd_data2(rd_data2), .halted(halted), .wr_count(wr_count),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    exp_regs[14] = 32'h0000_FFFC;
    step();
    step();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      rd_addr1 = 4'(i);
      #1 chk($sformatf("reset_r%0d", i), rd_data1, exp_regs[i]);
    end
    chk("reset_halted", {31'b0, halted}, 32'h0);
    chk("reset_wr_count", wr_count, 32'h0);
    chk("reset_dump_valid", {31'b0, dump_valid}, 32'h0);
    // same-cycle bypass on port 1, port 2 elsewhere
    wb_en = 1'b1; wb_rd = 4'd3; wb_data = 32'hDEAD_BEEF; rd_addr1 = 4'd3; rd_addr2 = 4'd4;
    #1 chk("bypass_r3", rd_data1, 32'hDEAD_BEEF);
    chk("nobypass_r4", rd_data2, 32'h0);
    step();
    wb_en = 1'b0;
    #1 chk("stored_r3", rd_data1, 32'hDEAD_BEEF);
    chk("wr_count_1", wr_count, 32'd1);
    exp_regs[3] = 32'hDEAD_BEEF;
    // call writeback: both ports bypass r15
    wb_en = 1'b1; wb_rd = 4'd15; wb_data = 32'h0000_0104; rd_addr1 = 4'd15; rd_addr2 = 4'd15;
    #1 chk("call_byp1", rd_data1, 32'h104);
    chk("call_byp2", rd_data2, 32'h104);
    step();
    wb_en = 1'b0;
    #1 chk("stored_r15", rd_data2, 32'h104);
    chk("wr_count_2", wr_count, 32'd2);
    exp_regs[15] = 32'h104;
    // last instruction with its own write
    wb_en = 1'b1; wb_rd = 4'd5; wb_data = 32'd7; wb_last = 1'b1;
    #1 chk("pre_halt_halted", {31'b0, halted}, 32'h0);
    step();
    exp_regs[5] = 32'd7;
    wb_last = 1'b0; wb_en = 1'b1; wb_rd = 4'd5; wb_data = 32'd9; rd_addr1 = 4'd5; rd_addr2 = 4'd3;
    #1 chk("halted", {31'b0, halted}, 32'h1);
    chk("wr_count_3", wr_count, 32'd3);
    chk("halt_nobypass_r5", rd_data1, 32'd7);
    chk("halt_read_r3", rd_data2, 32'hDEAD_BEEF);
`ifdef REGFILE_DUMP_EN
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("dump_valid_%0d", i), {31'b0, dump_valid}, 32'h1);
      chk($sformatf("dump_idx_%0d", i), {28'b0, dump_idx}, 32'(i));
      chk($sformatf("dump_data_%0d", i), dump_data, exp_regs[i]);
      chk($sformatf("dump_halted_%0d", i), {31'b0, halted}, 32'h1);
      step();
    end
    chk("dump_done_valid", {31'b0, dump_valid}, 32'h0);
`else
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("nodump_valid_%0d", i), {31'b0, dump_valid}, 32'h0);
      chk($sformatf("nodump_data_%0d", i), dump_data | {28'b0, dump_idx}, 32'h0);
      step();
    end
`endif
    chk("frozen_r5", rd_data1, 32'd7);
    chk("frozen_count", wr_count, 32'd3);
    chk("still_halted", {31'b0, halted}, 32'h1);
    wb_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_addr2 = 4'(i);
      #1 chk($sformatf("halt_r%0d", i), rd_data2, exp_regs[i]);
    end
    // reset out of HALT
    reset = 1'b1;
    step();
    reset = 1'b0; rd_addr1 = 4'd3; rd_addr2 = 4'd14;
    #1 chk("rst_halt_halted", {31'b0, halted}, 32'h0);
    chk("rst_halt_r3", rd_data1, 32'h0);
    chk("rst_halt_r14", rd_data2, 32'h0000_FFFC);
    chk("rst_halt_count", wr_count, 32'h0);
`ifdef REGFILE_DUMP_EN
    // reset in the middle of a dump
    wb_en = 1'b1; wb_rd = 4'd5; wb_data = 32'd7; wb_last = 1'b1;
    step();
    wb_en = 1'b0; wb_last = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("mid_dump_idx", {28'b0, dump_idx}, 32'd8);
    chk("mid_dump_valid", {31'b0, dump_valid}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0; rd_addr1 = 4'd5;
    #1 chk("rst_dump_valid", {31'b0, dump_valid}, 32'h0);
    chk("rst_dump_halted", {31'b0, halted}, 32'h0);
    chk("rst_dump_r5", rd_data1, 32'h0);
    wb_en = 1'b1; wb_rd = 4'd2; wb_data = 32'h55; rd_addr1 = 4'd2;
    #1 chk("rst_dump_run_bypass", rd_data1, 32'h55);
    wb_en = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
`endif
    // counter wrap
    force dut.r_wr_count = 32'hFFFF_FFFF;
    #1 release dut.r_wr_count;
    #1 chk("preload_count", wr_count, 32'hFFFF_FFFF);
    wb_en = 1'b1; wb_rd = 4'd0; wb_data = 32'h1234_5678; rd_addr1 = 4'd0;
    step();
    wb_en = 1'b0;
    #1 chk("wrap_count", wr_count, 32'h0);
    chk("r0_writable", rd_data1, 32'h1234_5678);
    $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
